// File: rtl/shared_mem_arbiter.sv
// Grant FSM that shares one memory port between instruction fetch and data load/store.
// Build option ARB_STARVE_GUARD_EN: forces a fetch grant after STARVE_LIMIT back-to-back data grants.
`timescale 1ns/1ps
module shared_mem_arbiter #(
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    if (MEM_LAT < 1 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("shared_mem_arbiter: MEM_LAT and STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    state_t             state;
    state_t             state_next;
    owner_t             owner;
    logic               op_wr;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        if_rdata_q;
    logic [31:0]        d_rdata_q;

    logic               data_req;
    logic               grant;
    logic               grant_data;
    logic               last_beat;
    logic               starve_hit;

    assign data_req  = d_rd | d_wr;
    assign grant     = (state == IDLE) && (data_req || if_req);
    assign last_beat = (state == ACCESS) && (cnt == '0);

    // Data wins ties unless the starvation guard has tripped with fetch still waiting.
    always_comb begin
        grant_data = data_req;
        if (starve_hit && if_req) begin
            grant_data = 1'b0;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (grant && !grant_data) begin
                starve_cnt <= '0;
            end else if (grant && grant_data && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer latches: captured once at grant, so requester changes mid-transfer are invisible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner      <= OWN_FETCH;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant) begin
                owner   <= grant_data ? OWN_DATA : OWN_FETCH;
                op_wr   <= grant_data & d_wr;
                addr_q  <= grant_data ? d_addr : if_addr;
                wdata_q <= grant_data ? d_wdata : '0;
                cnt     <= CNT_W'(MEM_LAT - 1);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (last_beat && !op_wr) begin
                if (owner == OWN_DATA) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd    = (state == ACCESS) && !op_wr;
        mem_wr    = (state == ACCESS) && op_wr;
        if_ack    = (state == DONE) && (owner == OWN_FETCH);
        d_ack     = (state == DONE) && (owner == OWN_DATA);
        busy      = (state != IDLE);
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: per-cycle vector table plus reset and starvation sequences.
`timescale 1ns/1ps
module tb_shared_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shared_mem_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    logic [132:0] act;
    assign act = {busy, mem_rd, mem_wr, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata};

    typedef struct {
        logic         if_req;
        logic [31:0]  if_addr;
        logic         d_rd;
        logic         d_wr;
        logic [31:0]  d_addr;
        logic [31:0]  d_wdata;
        logic [31:0]  mem_rdata;
        logic [132:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                       input logic e_busy, input logic e_rd, input logic e_wr,
                       input logic e_iack, input logic e_dack,
                       input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                       input logic [31:0] e_irdata, input logic [31:0] e_drdata);
        vec_t v;
        v.if_req    = ir;
        v.if_addr   = ia;
        v.d_rd      = dr;
        v.d_wr      = dw;
        v.d_addr    = da;
        v.d_wdata   = dwd;
        v.mem_rdata = mrd;
        v.exp = {e_busy, e_rd, e_wr, e_iack, e_dack, e_maddr, e_mwdata, e_irdata, e_drdata};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [132:0] got, input logic [132:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int    n_iack;
        int    n_dack;
        int    overlap;
        bit    acks[$];

        // fetch 0x10
        add(1, 32'h10, 0, 0, 0, 0, 0,                     1, 1, 0, 0, 0, 32'h10, 0, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 32'h20080005,          1, 1, 0, 0, 0, 32'h10, 0, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 32'h20080005,          1, 0, 0, 1, 0, 32'h10, 0, 32'h20080005, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 32'h10, 0, 32'h20080005, 0);
        // store 0x40
        add(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 0,          1, 0, 1, 0, 0, 32'h40, 32'hDEADBEEF, 32'h20080005, 0);
        add(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'h11111111, 1, 0, 1, 0, 0, 32'h40, 32'hDEADBEEF, 32'h20080005, 0);
        add(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'h11111111, 1, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'h20080005, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF, 32'h20080005, 0);
        // contention: load 0x40 wins, d_addr moves to 0x80 mid-transfer, then fetch 0x20
        add(1, 32'h20, 1, 0, 32'h40, 0, 0,                1, 1, 0, 0, 0, 32'h40, 0, 32'h20080005, 0);
        add(1, 32'h20, 1, 0, 32'h80, 0, 32'hCAFEF00D,     1, 1, 0, 0, 0, 32'h40, 0, 32'h20080005, 0);
        add(1, 32'h20, 1, 0, 32'h80, 0, 32'hCAFEF00D,     1, 0, 0, 0, 1, 32'h40, 0, 32'h20080005, 32'hCAFEF00D);
        add(1, 32'h20, 0, 0, 32'h80, 0, 0,                0, 0, 0, 0, 0, 32'h40, 0, 32'h20080005, 32'hCAFEF00D);
        add(1, 32'h20, 0, 0, 32'h80, 0, 0,                1, 1, 0, 0, 0, 32'h20, 0, 32'h20080005, 32'hCAFEF00D);
        add(1, 32'h20, 0, 0, 32'h80, 0, 32'h12345678,     1, 1, 0, 0, 0, 32'h20, 0, 32'h20080005, 32'hCAFEF00D);
        add(1, 32'h20, 0, 0, 32'h80, 0, 32'h12345678,     1, 0, 0, 1, 0, 32'h20, 0, 32'h12345678, 32'hCAFEF00D);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 32'h20, 0, 32'h12345678, 32'hCAFEF00D);
        // rd+wr together acts as a store
        add(0, 0, 1, 1, 32'h44, 32'h0BADF00D, 32'h55555555, 1, 0, 1, 0, 0, 32'h44, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D);
        add(0, 0, 1, 1, 32'h44, 32'h0BADF00D, 32'h55555555, 1, 0, 1, 0, 0, 32'h44, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D);
        add(0, 0, 1, 1, 32'h44, 32'h0BADF00D, 32'h55555555, 1, 0, 0, 0, 1, 32'h44, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 32'h44, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D);

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", act, '0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            d_rd      = vecs[i].d_rd;
            d_wr      = vecs[i].d_wr;
            d_addr    = vecs[i].d_addr;
            d_wdata   = vecs[i].d_wdata;
            mem_rdata = vecs[i].mem_rdata;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // reset while a load is in flight
        d_rd = 1'b1;
        d_addr = 32'h60;
        mem_rdata = 32'h77777777;
        @(posedge clock);
        #1;
        check("load_started", {131'd0, busy, mem_rd}, {131'd0, 2'b11});
        reset = 1'b1;
        #1;
        check("async_reset_busy_rd", {131'd0, busy, mem_rd}, '0);
        check("async_reset_outputs", act, '0);
        d_rd = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_dack = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            if (d_ack) n_dack++;
        end
        check("no_ack_after_reset", 133'(n_dack), '0);
        check("idle_after_reset", act, '0);

        // both requesters held high continuously
        d_rd = 1'b1;
        if_req = 1'b1;
        d_addr = 32'h100;
        if_addr = 32'h200;
        n_iack = 0;
        n_dack = 0;
        overlap = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (if_ack && d_ack) overlap++;
            if (if_ack) begin n_iack++; acks.push_back(1'b1); end
            if (d_ack) begin n_dack++; acks.push_back(1'b0); end
        end
        d_rd = 1'b0;
        if_req = 1'b0;
        check("acks_never_overlap", 133'(overlap), '0);
        check("transfers_in_40_cycles", 133'(n_iack + n_dack), 133'(10));
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 6; k++) begin
            logic want;
            want = (k == 4);
            if (k < acks.size())
                check($sformatf("starve_order%0d", k), 133'(acks[k]), 133'(want));
            else
                check($sformatf("starve_order%0d", k), 133'(acks.size()), 133'(k + 1));
        end
`else
        check("no_fetch_while_data", 133'(n_iack), '0);
        check("all_data_acks", 133'(n_dack), 133'(10));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
